// File: rtl/udp_vlg_rx_if.sv
// udp_vlg_rx_if
// Stream bundle around the UDP receive parser.
//   in_*  : IPv4 payload byte stream plus the IPv4 metadata that stays stable
//           for the whole datagram (protocol, source address, payload length)
//   out_* : UDP payload byte stream plus per-datagram UDP metadata
// Modports:
//   master : drives in_*, observes out_* (IPv4 side / stimulus)
//   slave  : observes in_*, drives out_* (the parser itself)
interface udp_vlg_rx_if;
  logic [7:0]  in_dat;
  logic        in_val;
  logic        in_sof;
  logic        in_eof;
  logic        in_err;
  logic [7:0]  in_proto;
  logic [31:0] in_src_ip;
  logic [15:0] in_pld_len;

  logic [7:0]  out_dat;
  logic        out_val;
  logic        out_sof;
  logic        out_eof;
  logic        out_err;
  logic [31:0] out_src_ip;
  logic [15:0] out_src_port;
  logic [15:0] out_dst_port;
  logic [15:0] out_len;
  logic [15:0] out_cks;

  modport master (
    output in_dat, in_val, in_sof, in_eof, in_err, in_proto, in_src_ip, in_pld_len,
    input  out_dat, out_val, out_sof, out_eof, out_err,
           out_src_ip, out_src_port, out_dst_port, out_len, out_cks
  );

  modport slave (
    input  in_dat, in_val, in_sof, in_eof, in_err, in_proto, in_src_ip, in_pld_len,
    output out_dat, out_val, out_sof, out_eof, out_err,
           out_src_ip, out_src_port, out_dst_port, out_len, out_cks
  );
endinterface

// File: rtl/udp_vlg_rx.sv
// udp_vlg_rx
// Receive-side UDP parser sitting behind the IPv4 receive stage. Strips and
// validates the 8-byte UDP header, optionally filters on destination port,
// forwards the UDP payload with one cycle of latency and trims Ethernet
// padding using the UDP length field.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   rx        : slave side of udp_vlg_rx_if (in_* stream in, out_* stream out)
//   dev_port  : local UDP port used by the destination filter
//   drop_cnt  : saturating count of dropped UDP datagrams
module udp_vlg_rx #(
  parameter bit PORT_FILTER_EN = 1'b1,
  parameter bit CHECK_LEN      = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  udp_vlg_rx_if.slave   rx,
  input  logic [15:0]   dev_port,
  output logic [15:0]   drop_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, PLD, SKIP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  hdr_cnt;
  logic [55:0] hdr_sr;
  logic [15:0] pld_len_q;
  logic [31:0] src_ip_q;
  logic [15:0] pld_cnt;

  logic        sof_v, eof_v, is_udp, hdr_last, hdr_fail, pld_done;
  logic [15:0] h_src, h_dst, h_len, h_cks;
  logic        emit_val, emit_sof, emit_eof, emit_err, drop_inc, meta_load;

  assign sof_v  = rx.in_val & rx.in_sof;
  assign eof_v  = rx.in_val & rx.in_eof;
  assign is_udp = (rx.in_proto == 8'd17);

  // Header bytes 0..6 sit in the shift register (byte 0 oldest); byte 7
  // is still on in_dat when the header is judged.
  assign h_src    = hdr_sr[55:40];
  assign h_dst    = hdr_sr[39:24];
  assign h_len    = hdr_sr[23:8];
  assign h_cks    = {hdr_sr[7:0], rx.in_dat};
  assign hdr_last = (hdr_cnt == 3'd7);
  assign hdr_fail = (h_len < 16'd8) ||
                    (CHECK_LEN && (h_len > pld_len_q)) ||
                    (PORT_FILTER_EN && (h_dst != dev_port));
  assign pld_done = ((pld_cnt + 16'd1) == rx.out_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A fresh in_sof always restarts parsing, whatever state we are in.
  always_comb begin
    state_nxt = state;
    if (sof_v) begin
      state_nxt = (is_udp && !rx.in_eof && !rx.in_err) ? HDR : IDLE;
    end else begin
      case (state)
        HDR: begin
          if (rx.in_err) begin
            state_nxt = IDLE;
          end else if (rx.in_val) begin
            if (hdr_last) begin
              if (rx.in_eof)                          state_nxt = IDLE;
              else if (hdr_fail || (h_len == 16'd8))  state_nxt = SKIP;
              else                                    state_nxt = PLD;
            end else if (rx.in_eof) begin
              state_nxt = IDLE;
            end
          end
        end
        PLD: begin
          if (rx.in_err || eof_v)         state_nxt = IDLE;
          else if (rx.in_val && pld_done) state_nxt = SKIP;
        end
        SKIP: begin
          if (rx.in_err || eof_v) state_nxt = IDLE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Decides what the registered outputs show on the next cycle and
  // whether this cycle costs a dropped datagram.
  always_comb begin
    emit_val  = 1'b0;
    emit_sof  = 1'b0;
    emit_eof  = 1'b0;
    emit_err  = 1'b0;
    drop_inc  = 1'b0;
    meta_load = 1'b0;
    if (sof_v) begin
      if (state == PLD) begin
        emit_eof = 1'b1;
        emit_err = 1'b1;
        drop_inc = 1'b1;
      end
      if (is_udp && (rx.in_eof || rx.in_err)) drop_inc = 1'b1;
    end else begin
      case (state)
        HDR: begin
          if (rx.in_err) begin
            drop_inc = 1'b1;
          end else if (rx.in_val) begin
            if (hdr_last) begin
              if (hdr_fail) drop_inc  = 1'b1;
              else          meta_load = 1'b1;
            end else if (rx.in_eof) begin
              drop_inc = 1'b1;
            end
          end
        end
        PLD: begin
          emit_val = rx.in_val;
          emit_sof = rx.in_val && (pld_cnt == 16'd0);
          if (rx.in_err) begin
            emit_eof = 1'b1;
            emit_err = 1'b1;
            drop_inc = 1'b1;
          end else if (rx.in_val) begin
            if (pld_done) begin
              emit_eof = 1'b1;
            end else if (rx.in_eof) begin
              emit_eof = 1'b1;
              emit_err = 1'b1;
              drop_inc = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx.out_dat      <= 8'h00;
      rx.out_val      <= 1'b0;
      rx.out_sof      <= 1'b0;
      rx.out_eof      <= 1'b0;
      rx.out_err      <= 1'b0;
      rx.out_src_ip   <= 32'h0;
      rx.out_src_port <= 16'h0;
      rx.out_dst_port <= 16'h0;
      rx.out_len      <= 16'h0;
      rx.out_cks      <= 16'h0;
      drop_cnt        <= 16'h0;
      hdr_cnt         <= 3'd0;
      hdr_sr          <= 56'h0;
      pld_len_q       <= 16'h0;
      src_ip_q        <= 32'h0;
      pld_cnt         <= 16'h0;
    end else begin
      rx.out_val <= emit_val;
      rx.out_sof <= emit_sof;
      rx.out_eof <= emit_eof;
      rx.out_err <= emit_err;
      if (emit_val) rx.out_dat <= rx.in_dat;
      if (drop_inc && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;

      if (sof_v) begin
        hdr_cnt   <= 3'd1;
        hdr_sr    <= {48'h0, rx.in_dat};
        pld_len_q <= rx.in_pld_len;
        src_ip_q  <= rx.in_src_ip;
      end else if ((state == HDR) && rx.in_val) begin
        hdr_cnt <= hdr_cnt + 3'd1;
        hdr_sr  <= {hdr_sr[47:0], rx.in_dat};
      end

      // Metadata only changes when a header passes, so it stays put across
      // dropped datagrams and idle time.
      if (meta_load) begin
        rx.out_src_ip   <= src_ip_q;
        rx.out_src_port <= h_src;
        rx.out_dst_port <= h_dst;
        rx.out_len      <= h_len - 16'd8;
        rx.out_cks      <= h_cks;
        pld_cnt         <= 16'h0;
      end else if ((state == PLD) && rx.in_val && !sof_v) begin
        pld_cnt <= pld_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_udp_vlg_rx.sv
// tb_udp_vlg_rx
// Directed bench for udp_vlg_rx. Two instances share one input stream: dut0
// filters on destination port, dut1 accepts every port. A datagram-level
// model predicts the output beats, drop counts and metadata of each instance.
module tb_udp_vlg_rx;

  localparam int T_EOF  = 0;
  localparam int T_ERR  = 1;
  localparam int T_SOF  = 2;
  localparam int T_NONE = 3;

  typedef struct packed {
    logic [7:0] dat;
    logic       val;
    logic       sof;
    logic       eof;
    logic       err;
  } beat_t;

  typedef struct {
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] len;
    logic [15:0] cks;
  } meta_t;

  logic        clk;
  logic        rst;
  logic [15:0] dev_port;
  logic [15:0] drop0, drop1;

  udp_vlg_rx_if ifc0 ();
  udp_vlg_rx_if ifc1 ();

  assign ifc1.in_dat     = ifc0.in_dat;
  assign ifc1.in_val     = ifc0.in_val;
  assign ifc1.in_sof     = ifc0.in_sof;
  assign ifc1.in_eof     = ifc0.in_eof;
  assign ifc1.in_err     = ifc0.in_err;
  assign ifc1.in_proto   = ifc0.in_proto;
  assign ifc1.in_src_ip  = ifc0.in_src_ip;
  assign ifc1.in_pld_len = ifc0.in_pld_len;

  udp_vlg_rx #(.PORT_FILTER_EN(1'b1), .CHECK_LEN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .rx(ifc0.slave), .dev_port(dev_port), .drop_cnt(drop0)
  );

  udp_vlg_rx #(.PORT_FILTER_EN(1'b0), .CHECK_LEN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .rx(ifc1.slave), .dev_port(dev_port), .drop_cnt(drop1)
  );

  int         checks;
  int         errors;
  beat_t      exp_q0[$];
  beat_t      exp_q1[$];
  meta_t      exp_meta[2];
  int         exp_drop[2];
  logic [7:0] pkt[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic beat_t actBeat(input int d);
    beat_t b;
    if (d == 0) begin
      b.dat = ifc0.out_dat; b.val = ifc0.out_val; b.sof = ifc0.out_sof;
      b.eof = ifc0.out_eof; b.err = ifc0.out_err;
    end else begin
      b.dat = ifc1.out_dat; b.val = ifc1.out_val; b.sof = ifc1.out_sof;
      b.eof = ifc1.out_eof; b.err = ifc1.out_err;
    end
    if (!b.val) b.dat = 8'h00;
    return b;
  endfunction

  task automatic pushBeat(input int d, input beat_t b);
    if (d == 0) exp_q0.push_back(b);
    else        exp_q1.push_back(b);
  endtask

  task automatic bumpDrop(input int d);
    if (exp_drop[d] < 65535) exp_drop[d]++;
  endtask

  // Output activity on any flag is matched, in order, against the model.
  task automatic compareBeat(input int d);
    beat_t a, e;
    a = actBeat(d);
    if (a.val || a.sof || a.eof || a.err) begin
      if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
        checkOutput($sformatf("spurious_beat_dut%0d", d), 32'(a), 32'h0);
      end else begin
        if (d == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        checkOutput($sformatf("beat_dut%0d", d), 32'(a), 32'(e));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) compareBeat(d);
    end
  end

  // Whole-datagram model: what the application side must see for pkt[].
  task automatic modelDatagram(input int d, input logic [7:0] proto, input logic [15:0] ip_len,
                               input logic [31:0] sip, input int term);
    int          n, p, plen;
    logic [15:0] ulen, dport;
    beat_t       b;
    n = pkt.size();
    if (proto != 8'd17) return;
    if (n < 8) begin
      if (term == T_EOF || term == T_ERR) bumpDrop(d);
      return;
    end
    dport = {pkt[2], pkt[3]};
    ulen  = {pkt[4], pkt[5]};
    if (ulen < 16'd8 || ulen > ip_len || (d == 0 && dport != dev_port)) begin
      bumpDrop(d);
      return;
    end
    exp_meta[d].src_ip   = sip;
    exp_meta[d].src_port = {pkt[0], pkt[1]};
    exp_meta[d].dst_port = dport;
    exp_meta[d].len      = ulen - 16'd8;
    exp_meta[d].cks      = {pkt[6], pkt[7]};
    plen = int'(ulen) - 8;
    p    = n - 8;
    for (int i = 0; i < p && i < plen; i++) begin
      b.dat = pkt[8+i];
      b.val = 1'b1;
      b.sof = (i == 0);
      b.err = (term == T_EOF) && (p < plen) && (i == p - 1);
      b.eof = (i == plen - 1) || b.err;
      pushBeat(d, b);
    end
    if (p < plen && term != T_NONE) begin
      if (term != T_EOF) begin
        b = '0;
        b.eof = 1'b1;
        b.err = 1'b1;
        pushBeat(d, b);
      end
      bumpDrop(d);
    end
  endtask

  task automatic mkHdr(input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] ulen,
                       input logic [15:0] cks);
    pkt.delete();
    pkt.push_back(sp[15:8]);   pkt.push_back(sp[7:0]);
    pkt.push_back(dp[15:8]);   pkt.push_back(dp[7:0]);
    pkt.push_back(ulen[15:8]); pkt.push_back(ulen[7:0]);
    pkt.push_back(cks[15:8]);  pkt.push_back(cks[7:0]);
  endtask

  task automatic addPld(input int n, input logic [7:0] seed);
    for (int i = 0; i < n; i++) pkt.push_back(seed + 8'(i));
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ifc0.in_val = 1'b0; ifc0.in_sof = 1'b0; ifc0.in_eof = 1'b0;
      ifc0.in_err = 1'b0; ifc0.in_dat = 8'h00;
    end
  endtask

  // Drives pkt[] one byte per cycle; term picks how the datagram ends.
  task automatic applyStimulus(input logic [7:0] proto, input logic [15:0] ip_len,
                               input logic [31:0] sip, input int term);
    modelDatagram(0, proto, ip_len, sip, term);
    modelDatagram(1, proto, ip_len, sip, term);
    for (int i = 0; i < pkt.size(); i++) begin
      @(posedge clk); #1;
      ifc0.in_val     = 1'b1;
      ifc0.in_dat     = pkt[i];
      ifc0.in_sof     = (i == 0);
      ifc0.in_eof     = (term == T_EOF) && (i == pkt.size() - 1);
      ifc0.in_err     = 1'b0;
      ifc0.in_proto   = proto;
      ifc0.in_src_ip  = sip;
      ifc0.in_pld_len = ip_len;
    end
    if (term == T_ERR) begin
      @(posedge clk); #1;
      ifc0.in_val = 1'b0; ifc0.in_sof = 1'b0; ifc0.in_eof = 1'b0; ifc0.in_err = 1'b1;
    end
  endtask

  task automatic endChecks(input string tag);
    checkOutput({tag, "_pending0"}, 32'(exp_q0.size()), 32'h0);
    checkOutput({tag, "_pending1"}, 32'(exp_q1.size()), 32'h0);
    checkOutput({tag, "_drop0"}, 32'(drop0), 32'(exp_drop[0]));
    checkOutput({tag, "_drop1"}, 32'(drop1), 32'(exp_drop[1]));
    checkOutput({tag, "_src_ip0"},   ifc0.out_src_ip,          exp_meta[0].src_ip);
    checkOutput({tag, "_src_port0"}, 32'(ifc0.out_src_port),   32'(exp_meta[0].src_port));
    checkOutput({tag, "_dst_port0"}, 32'(ifc0.out_dst_port),   32'(exp_meta[0].dst_port));
    checkOutput({tag, "_len0"},      32'(ifc0.out_len),        32'(exp_meta[0].len));
    checkOutput({tag, "_cks0"},      32'(ifc0.out_cks),        32'(exp_meta[0].cks));
    checkOutput({tag, "_src_port1"}, 32'(ifc1.out_src_port),   32'(exp_meta[1].src_port));
    checkOutput({tag, "_dst_port1"}, 32'(ifc1.out_dst_port),   32'(exp_meta[1].dst_port));
    checkOutput({tag, "_len1"},      32'(ifc1.out_len),        32'(exp_meta[1].len));
  endtask

  task automatic resetModel();
    exp_q0.delete();
    exp_q1.delete();
    for (int d = 0; d < 2; d++) begin
      exp_drop[d] = 0;
      exp_meta[d] = '{default: '0};
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    dev_port = 16'd1234;
    ifc0.in_dat = 8'h00; ifc0.in_val = 1'b0; ifc0.in_sof = 1'b0; ifc0.in_eof = 1'b0;
    ifc0.in_err = 1'b0; ifc0.in_proto = 8'h00; ifc0.in_src_ip = 32'h0; ifc0.in_pld_len = 16'h0;
    resetModel();

    // Reset state, seen before any clock edge
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_out_val", 32'(ifc0.out_val), 32'h0);
    checkOutput("reset_drop", 32'(drop0), 32'h0);
    checkOutput("reset_len", 32'(ifc0.out_len), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] accept");
    mkHdr(16'h1F90, 16'h04D2, 16'h000C, 16'hABCD);
    pkt.push_back(8'hDE); pkt.push_back(8'hAD); pkt.push_back(8'hBE); pkt.push_back(8'hEF);
    applyStimulus(8'd17, 16'd12, 32'hC0A80001, T_EOF);
    checkOutput("accept_lat_prev", {ifc0.out_val, ifc0.out_dat}, {1'b1, 8'hBE});
    idleCycles(1);
    checkOutput("accept_lat_last", {ifc0.out_dat, ifc0.out_eof}, {8'hEF, 1'b1});
    idleCycles(3);
    endChecks("accept");
    checkOutput("accept_src_port_lit", 32'(ifc0.out_src_port), 32'd8080);
    checkOutput("accept_len_lit", 32'(ifc0.out_len), 32'd4);
    checkOutput("accept_cks_lit", 32'(ifc0.out_cks), 32'hABCD);
    checkOutput("accept_drop_lit", 32'(drop0), 32'd0);

    $display("[TB] padding then back-to-back");
    mkHdr(16'h1111, 16'd1234, 16'd9, 16'h0000);
    pkt.push_back(8'h55);
    addPld(17, 8'h00);
    applyStimulus(8'd17, 16'd26, 32'h0A000001, T_EOF);
    mkHdr(16'h2222, 16'd1234, 16'd10, 16'h1234);
    pkt.push_back(8'hA1); pkt.push_back(8'hA2);
    applyStimulus(8'd17, 16'd10, 32'h0A000002, T_EOF);
    idleCycles(3);
    endChecks("padding");
    checkOutput("padding_len_lit", 32'(ifc0.out_len), 32'd2);

    $display("[TB] filtering");
    mkHdr(16'h3333, 16'd80, 16'd12, 16'h0000);
    addPld(4, 8'h10);
    applyStimulus(8'd17, 16'd12, 32'h0A000003, T_EOF);
    idleCycles(3);
    endChecks("filter");
    checkOutput("filter_drop0_lit", 32'(drop0), 32'd1);
    checkOutput("filter_dut1_dst_lit", 32'(ifc1.out_dst_port), 32'd80);
    applyStimulus(8'd6, 16'd12, 32'h0A000004, T_EOF);
    idleCycles(3);
    endChecks("proto6");
    checkOutput("proto6_drop0_lit", 32'(drop0), 32'd1);

    $display("[TB] bad length");
    mkHdr(16'h0001, 16'd1234, 16'd4, 16'h0000);
    applyStimulus(8'd17, 16'd8, 32'h0A000005, T_EOF);
    idleCycles(2);
    checkOutput("short_len_drop_lit", 32'(drop0), 32'd2);
    mkHdr(16'h0001, 16'd1234, 16'd40, 16'h0000);
    addPld(12, 8'h20);
    applyStimulus(8'd17, 16'd20, 32'h0A000006, T_EOF);
    idleCycles(2);
    checkOutput("long_len_drop_lit", 32'(drop0), 32'd3);
    mkHdr(16'h0005, 16'd1234, 16'd20, 16'h7777);
    addPld(5, 8'h30);
    applyStimulus(8'd17, 16'd20, 32'h0A000007, T_EOF);
    idleCycles(3);
    endChecks("trunc");
    checkOutput("trunc_drop_lit", 32'(drop0), 32'd4);

    $display("[TB] abort");
    mkHdr(16'h0006, 16'd1234, 16'd16, 16'h0000);
    addPld(3, 8'h40);
    applyStimulus(8'd17, 16'd16, 32'h0A000008, T_ERR);
    idleCycles(2);
    checkOutput("err_drop_lit", 32'(drop0), 32'd5);
    mkHdr(16'h0007, 16'd1234, 16'd16, 16'h0000);
    addPld(2, 8'h50);
    applyStimulus(8'd17, 16'd16, 32'h0A000009, T_SOF);
    mkHdr(16'h0008, 16'd1234, 16'd11, 16'hBEEF);
    addPld(3, 8'h60);
    applyStimulus(8'd17, 16'd11, 32'h0A00000A, T_EOF);
    idleCycles(3);
    endChecks("sof_abort");
    checkOutput("sof_abort_drop_lit", 32'(drop0), 32'd6);
    checkOutput("sof_abort_len_lit", 32'(ifc0.out_len), 32'd3);

    $display("[TB] reset mid-payload");
    mkHdr(16'h0009, 16'd1234, 16'd20, 16'h0000);
    addPld(4, 8'h70);
    applyStimulus(8'd17, 16'd20, 32'h0A00000B, T_NONE);
    idleCycles(1);
    checkOutput("rst_pre_val", {ifc0.out_val, ifc0.out_dat}, {1'b1, 8'h73});
    #1 rst = 1'b1;
    resetModel();
    #1;
    checkOutput("rst_async_val", 32'(ifc0.out_val), 32'h0);
    checkOutput("rst_async_dat", 32'(ifc0.out_dat), 32'h0);
    checkOutput("rst_async_len", 32'(ifc0.out_len), 32'h0);
    checkOutput("rst_async_drop", 32'(drop0), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mkHdr(16'h000A, 16'd1234, 16'd11, 16'h0001);
    addPld(3, 8'h80);
    applyStimulus(8'd17, 16'd11, 32'h0A00000C, T_EOF);
    mkHdr(16'h000B, 16'd1234, 16'd10, 16'h0002);
    addPld(2, 8'h90);
    applyStimulus(8'd17, 16'd10, 32'h0A00000D, T_EOF);
    idleCycles(3);
    endChecks("post_reset");
    checkOutput("post_reset_port_lit", 32'(ifc0.out_src_port), 32'h000B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
